// File: rtl/amm_slave_mem.sv
// Avalon-MM slave memory: word-addressed RAM with byteenable write bursts, fixed-latency read bursts and optional random waitrequest.
// Optional build macro AMM_SLAVE_MEM_ERR_INJECT_EN adds a single-address read-data bit-0 corruption port pair.
module amm_slave_mem #(
  parameter int unsigned AMM_DATA_W   = 128,
  parameter int unsigned AMM_ADDR_W   = 32,
  parameter int unsigned AMM_BURST_W  = 11,
  parameter int unsigned DATA_B_W     = AMM_DATA_W / 8,
  parameter int unsigned MEM_ADDR_W   = 10,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AMM_ADDR_W-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  input  logic [AMM_DATA_W-1:0]  writedata_i,
  input  logic [AMM_BURST_W-1:0] burstcount_i,
  input  logic [DATA_B_W-1:0]    byteenable_i,
  output logic                   waitrequest_o,
  output logic                   readdatavalid_o,
  output logic [AMM_DATA_W-1:0]  readdata_o,
  input  logic                   stall_en_i,
  output logic                   busy_o,
  output logic                   proto_err_o
`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
  ,
  input  logic                   err_inject_i,
  input  logic [MEM_ADDR_W-1:0]  err_addr_i
`endif
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_W;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                 state, state_n;
  logic [7:0]             lfsr;
  logic [MEM_ADDR_W-1:0]  addr_idx, waddr, raddr, mem_wa;
  logic [AMM_BURST_W-1:0] bc_eff, wcnt, rcnt;
  logic [READ_LATENCY-1:0] vld;
  logic [AMM_DATA_W-1:0]  dat [READ_LATENCY];
  logic [AMM_DATA_W-1:0]  mem [DEPTH];
  logic [AMM_DATA_W-1:0]  rd_word;
  logic                   stall, pend;
  logic                   wr_first, wr_beat, rd_acc, issue, err_set;
  logic                   unused_addr;

  assign addr_idx    = address_i[MEM_ADDR_W-1:0];
  assign unused_addr = ^address_i[AMM_ADDR_W-1:MEM_ADDR_W];
  assign bc_eff      = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;
  assign stall       = stall_en_i & lfsr[0];
  // Beats still travelling behind the output stage
  assign pend        = |vld[READ_LATENCY-2:0];
  assign busy_o          = (state != IDLE) | (|vld);
  assign readdatavalid_o = vld[READ_LATENCY-1];
  assign readdata_o      = dat[READ_LATENCY-1];
  assign mem_wa          = wr_first ? addr_idx : waddr;

`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
  assign rd_word = mem[raddr] ^ AMM_DATA_W'(err_inject_i && (raddr == err_addr_i));
`else
  assign rd_word = mem[raddr];
`endif

  // Next-state and handshake decode
  always_comb begin
    state_n       = state;
    waitrequest_o = rst_i | stall;
    wr_first      = 1'b0;
    wr_beat       = 1'b0;
    rd_acc        = 1'b0;
    issue         = 1'b0;
    err_set       = 1'b0;
    case (state)
      IDLE: begin
        if ((read_i | write_i) & !waitrequest_o) begin
          err_set = (read_i & write_i) | (burstcount_i == '0);
          if (write_i) begin
            wr_first = 1'b1;
            if (bc_eff != AMM_BURST_W'(1)) state_n = WR_BURST;
          end else begin
            rd_acc  = 1'b1;
            state_n = RD_BURST;
          end
        end
      end
      WR_BURST: begin
        err_set = read_i;
        if (write_i & !waitrequest_o) begin
          wr_beat = 1'b1;
          if (wcnt == AMM_BURST_W'(1)) state_n = IDLE;
        end
      end
      RD_BURST: begin
        waitrequest_o = 1'b1;
        issue         = (rcnt != '0);
        if ((rcnt == '0) && !pend && vld[READ_LATENCY-1]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM write port, byte-granular
  always_ff @(posedge clk_i) begin
    if (wr_first | wr_beat) begin
      for (int b = 0; b < int'(DATA_B_W); b++) begin
        if (byteenable_i[b]) mem[mem_wa][8*b +: 8] <= writedata_i[8*b +: 8];
      end
    end
  end

  // State, counters, stall LFSR and read pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      lfsr        <= 8'hFF;
      waddr       <= '0;
      raddr       <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      vld         <= '0;
      proto_err_o <= 1'b0;
      for (int k = 0; k < int'(READ_LATENCY); k++) dat[k] <= '0;
    end else begin
      state <= state_n;
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (err_set) proto_err_o <= 1'b1;
      if (wr_first) begin
        waddr <= addr_idx + MEM_ADDR_W'(1);
        wcnt  <= bc_eff - AMM_BURST_W'(1);
      end else if (wr_beat) begin
        waddr <= waddr + MEM_ADDR_W'(1);
        wcnt  <= wcnt - AMM_BURST_W'(1);
      end
      if (rd_acc) begin
        raddr <= addr_idx;
        rcnt  <= bc_eff;
      end else if (issue) begin
        raddr <= raddr + MEM_ADDR_W'(1);
        rcnt  <= rcnt - AMM_BURST_W'(1);
      end
      vld <= READ_LATENCY'({vld, issue});
      if (issue) dat[0] <= rd_word;
      // Data stages only move with a valid beat so the output holds between bursts
      for (int k = 1; k < int'(READ_LATENCY); k++) begin
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

endmodule

// File: tb/tb_amm_slave_mem.sv
// Directed self-checking bench for amm_slave_mem: bursts, byteenable, wrap, stalls, protocol errors, reset mid-read.
module tb_amm_slave_mem;

  localparam int RL = 4;

  logic         clk_i, rst_i;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [127:0] writedata_i;
  logic [10:0]  burstcount_i;
  logic [15:0]  byteenable_i;
  logic         waitrequest_o, readdatavalid_o;
  logic [127:0] readdata_o;
  logic         stall_en_i, busy_o, proto_err_o;
`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
  logic         err_inject_i;
  logic [9:0]   err_addr_i;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_q[$];

  amm_slave_mem dut (
    .clk_i(clk_i), .rst_i(rst_i), .address_i(address_i), .read_i(read_i), .write_i(write_i),
    .writedata_i(writedata_i), .burstcount_i(burstcount_i), .byteenable_i(byteenable_i),
    .waitrequest_o(waitrequest_o), .readdatavalid_o(readdatavalid_o), .readdata_o(readdata_o),
    .stall_en_i(stall_en_i), .busy_o(busy_o), .proto_err_o(proto_err_o)
`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
    , .err_inject_i(err_inject_i), .err_addr_i(err_addr_i)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int n, input logic [127:0] base,
                          input bit inc, input logic [15:0] be, input int drop_at, input bit both);
    int i, budget, drops;
    logic wr;
    i = 0; budget = 0; drops = (drop_at >= 0) ? 3 : 0;
    @(negedge clk_i);
    address_i = addr; burstcount_i = 11'(n); byteenable_i = be;
    while (i < n && budget < 500) begin
      read_i = both && (i == 0);
      if (i == drop_at && drops > 0) begin
        write_i = 1'b0;
        drops--;
      end else begin
        write_i     = 1'b1;
        writedata_i = inc ? base + 128'(i) : base;
      end
      #1 wr = waitrequest_o;
      @(posedge clk_i);
      if (write_i && !wr) i++;
      @(negedge clk_i);
      budget++;
    end
    write_i = 1'b0; read_i = 1'b0;
    chk("wr_beats", 128'(i), 128'(n));
  endtask

  task automatic do_read(input logic [31:0] addr, input int n, input int rst_after);
    int budget;
    logic wr;
    bit acc, stop;
    @(negedge clk_i);
    address_i = addr; burstcount_i = 11'(n); read_i = 1'b1; write_i = 1'b0;
    acc = 1'b0; budget = 0; stop = 1'b0;
    while (!acc && budget < 100) begin
      #1 wr = waitrequest_o;
      @(posedge clk_i);
      acc = !wr;
      @(negedge clk_i);
      budget++;
    end
    read_i = 1'b0;
    chk("rd_accept", 128'(acc), 128'(1));
    for (int c = 0; c <= RL + n && !stop; c++) begin
      if (c > 0) @(negedge clk_i);
      chk("rd_valid", 128'(readdatavalid_o), 128'(c >= RL && c < RL + n));
      if (c >= RL && c < RL + n) chk("rd_data", readdata_o, exp_q[c-RL]);
      if (rst_after > 0 && c == RL + rst_after - 1) begin
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_valid", 128'(readdatavalid_o), 128'(0));
        chk("rst_wait", 128'(waitrequest_o), 128'(1));
        chk("rst_busy", 128'(busy_o), 128'(0));
        rst_i = 1'b0;
        stop  = 1'b1;
      end else if (c == RL + n - 1) begin
        chk("rd_last_wait", 128'(waitrequest_o), 128'(1));
        chk("rd_last_busy", 128'(busy_o), 128'(1));
      end else if (c == RL + n) begin
        chk("rd_idle_wait", 128'(waitrequest_o), 128'(0));
        chk("rd_idle_busy", 128'(busy_o), 128'(0));
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; address_i = '0; read_i = 1'b0; write_i = 1'b0; writedata_i = '0;
    burstcount_i = '0; byteenable_i = '0; stall_en_i = 1'b0;
`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
    err_inject_i = 1'b0; err_addr_i = '0;
`endif
    repeat (3) @(negedge clk_i);
    chk("reset_wait", 128'(waitrequest_o), 128'(1));
    chk("reset_valid", 128'(readdatavalid_o), 128'(0));
    chk("reset_data", readdata_o, 128'(0));
    chk("reset_busy", 128'(busy_o), 128'(0));
    chk("reset_perr", 128'(proto_err_o), 128'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_wait", 128'(waitrequest_o), 128'(0));

    // 4-beat burst of a constant pattern
    do_write(32'h10, 4, {16{8'hA5}}, 1'b0, 16'hFFFF, -1, 1'b0);
    exp_q.delete();
    repeat (4) exp_q.push_back({16{8'hA5}});
    do_read(32'h10, 4, 0);

`ifdef AMM_SLAVE_MEM_ERR_INJECT_EN
    err_addr_i = 10'h012; err_inject_i = 1'b1;
    exp_q.delete();
    exp_q.push_back({16{8'hA5}});
    exp_q.push_back({16{8'hA5}});
    exp_q.push_back({{15{8'hA5}}, 8'hA4});
    exp_q.push_back({16{8'hA5}});
    do_read(32'h10, 4, 0);
    err_inject_i = 1'b0;
`endif

    // Byteenable merge on word 5
    do_write(32'h5, 1, {128{1'b1}}, 1'b0, 16'hFFFF, -1, 1'b0);
    do_write(32'h5, 1, 128'h0, 1'b0, 16'h000F, -1, 1'b0);
    exp_q.delete();
    exp_q.push_back(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_0000_0000);
    do_read(32'h5, 1, 0);

    // Wrap at the top of the RAM; upper address bits ignored
    do_write(32'hABC0_03FE, 4, 128'h5000, 1'b1, 16'hFFFF, -1, 1'b0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(128'h5000 + 128'(i));
    do_read(32'h3FE, 4, 0);
    exp_q.delete();
    exp_q.push_back(128'h5002);
    do_read(32'h0, 1, 0);

    // Stalled 8-beat write with write_i dropped for 3 cycles; neighbours must survive
    do_write(32'h1F, 1, 128'h1111, 1'b0, 16'hFFFF, -1, 1'b0);
    do_write(32'h28, 1, 128'h2222, 1'b0, 16'hFFFF, -1, 1'b0);
    stall_en_i = 1'b1;
    do_write(32'h20, 8, 128'hC0DE_0000, 1'b1, 16'hFFFF, 4, 1'b0);
    stall_en_i = 1'b0;
    exp_q.delete();
    exp_q.push_back(128'h1111);
    for (int i = 0; i < 8; i++) exp_q.push_back(128'hC0DE_0000 + 128'(i));
    exp_q.push_back(128'h2222);
    do_read(32'h1F, 10, 0);
    chk("perr_clean", 128'(proto_err_o), 128'(0));

    // Reset after the second of eight read beats, then a clean readback
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(128'hC0DE_0000 + 128'(i));
    do_read(32'h20, 8, 2);
    @(negedge clk_i);
    chk("post_rst_wait", 128'(waitrequest_o), 128'(0));
    do_read(32'h20, 8, 0);

    // read_i and write_i together: write wins, sticky error
    do_write(32'h40, 1, 128'hBEEF, 1'b0, 16'hFFFF, -1, 1'b1);
    @(negedge clk_i);
    chk("perr_set", 128'(proto_err_o), 128'(1));
    exp_q.delete();
    exp_q.push_back(128'hBEEF);
    do_read(32'h40, 1, 0);
    chk("perr_sticky", 128'(proto_err_o), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/amm_slave_mem.md
Name: amm_slave_mem

Overview:
- Synthesizable Avalon-MM slave memory model: the responder end of the checker's Avalon-MM master interface.
- Provides an internal word-addressed RAM. Write bursts are stored with byteenable. Read bursts are returned at a fixed latency.
- Waitrequest stalls are pseudo-random and can be enabled or disabled.
- Used for loopback of the memory checker in simulation and on-board self-test.

Parameters:
- AMM_DATA_W, 128, data bus width in bits.
- AMM_ADDR_W, 32, address bus width. The address is a word address.
- AMM_BURST_W, 11, burstcount width.
- DATA_B_W, AMM_DATA_W/8, byteenable width.
- MEM_ADDR_W, 10, log2 of RAM depth in words.
- READ_LATENCY, 4, cycles from read accept to the first readdatavalid_o. Range 2..16.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- address_i  in  AMM_ADDR_W  word address
- read_i  in  1  read request
- write_i  in  1  write request / write beat valid
- writedata_i  in  AMM_DATA_W  write data
- burstcount_i  in  AMM_BURST_W  burst length in words
- byteenable_i  in  DATA_B_W  per-byte write enable
- waitrequest_o  out  1  slave stall
- readdatavalid_o  out  1  read beat valid
- readdata_o  out  AMM_DATA_W  read data
- stall_en_i  in  1  enables random waitrequest
- busy_o  out  1  burst in progress
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset: state IDLE; waitrequest_o=1; readdatavalid_o=0; readdata_o=0; busy_o=0; proto_err_o=0; stall LFSR=8'hFF.
  - RAM contents are not reset.
  - Reset mid-burst discards the remainder of the burst. Read beats already in flight are dropped.
- Stall LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Advances every cycle outside reset.
- waitrequest_o:
  - In IDLE/WR_BURST: equals stall_en_i & lfsr[0].
  - In RD_BURST: forced to 1.
- RAM addressing: word index = address_i[MEM_ADDR_W-1:0]. Upper bits are ignored. A burst wraps modulo 2^MEM_ADDR_W.
- Burst length: burstcount_i=0 is treated as 1 and sets proto_err_o.
- States:
  - IDLE:
    - Accept = (read_i|write_i) & !waitrequest_o.
    - On write accept: write beat 0 to mem[addr] under byteenable_i. Latch addr+1 and remaining = burstcount-1. Go to WR_BURST if remaining!=0, else stay in IDLE.
    - On read accept: latch addr and count. Go to RD_BURST.
    - read_i&write_i together: the write wins and proto_err_o is set.
  - WR_BURST:
    - A beat is taken when write_i & !waitrequest_o. It writes mem[waddr], increments waddr, decrements remaining.
    - address_i and burstcount_i are ignored on these beats.
    - write_i low stalls; counter and address hold.
    - read_i asserted sets proto_err_o.
    - After the last beat, return to IDLE the next cycle.
  - RD_BURST:
    - Issue one RAM read per cycle into a READ_LATENCY-deep valid/data pipeline.
    - The first readdatavalid_o occurs exactly READ_LATENCY cycles after the accept edge. The remaining beats follow back-to-back with no gaps.
    - Return to IDLE in the cycle after the last beat's readdatavalid_o.
    - readdata_o holds its last value when readdatavalid_o=0.
- busy_o = (state != IDLE) or pipeline non-empty.
- Only one command is outstanding. No new command is accepted until the read burst has fully returned.
- proto_err_o is cleared only by reset.

Optional Feature:
- Macro: AMM_SLAVE_MEM_ERR_INJECT_EN.
- Defined:
  - Adds ports err_inject_i (in, 1) and err_addr_i (in, MEM_ADDR_W).
  - A read beat whose word index equals err_addr_i while err_inject_i=1 returns readdata with bit 0 inverted. The RAM is not modified.
- Undefined: the ports are absent and read data is returned unmodified.

Test Plan:
- Write burst, stall_en_i=0: addr=0x10, burstcount=4, byteenable all ones, data 0xA5 pattern. Then read addr=0x10, burstcount=4 -> 4 beats of 0xA5..., first readdatavalid_o 4 cycles after accept, no gaps.
- Byteenable: write 0xFF..FF to word 5, then write 0x00.. to word 5 with byteenable=16'h000F. Read word 5 -> low 4 bytes 0x00, remaining bytes 0xFF.
- Wrap-around: write burst at addr 0x3FE, burstcount=4 -> words 0x3FE, 0x3FF, 0x000, 0x001 are written. A readback at 0x3FE returns them in order.
- Stall/protocol: stall_en_i=1 during an 8-beat write, with write_i dropped for 3 cycles mid-burst -> exactly 8 words are stored. read_i&write_i in IDLE -> proto_err_o=1 and stays 1.
- Reset: assert rst_i after the 2nd of 8 read beats -> readdatavalid_o=0 on the next cycle, waitrequest_o=1 and busy_o=0. A post-reset read returns the stored data.
- With AMM_SLAVE_MEM_ERR_INJECT_EN: err_addr_i=0x12, err_inject_i=1, 4-beat read at 0x10 -> beat 2 has bit 0 flipped, the other beats are exact.
